// File: rtl/pingpong_bank_buffer_if.sv
// Producer/consumer stream bundle for the ping-pong bank buffer.
// The master drives the producer data and the consumer ready; the slave is the buffer.
interface pingpong_bank_buffer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [LW-1:0]    out_len;
    logic             out_ready;
    logic [1:0]       bank_full;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_len, bank_full
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_len, bank_full
    );
endinterface

// File: rtl/pingpong_bank_buffer.sv
// Double-bank buffer: the producer fills one bank while the consumer drains the other.
// Every output is decoded from registered state only, so no ready/valid path crosses the block.
module pingpong_bank_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset_n,
    pingpong_bank_buffer_if.slave bus_io
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [0:0] BANK_EMPTY  = 1'b0;
    localparam logic [0:0] BANK_CLOSED = 1'b1;

    logic [1:0]       full_q,   full_d;
    logic [LW-1:0]    len0_q,   len0_d;
    logic [LW-1:0]    len1_q,   len1_d;
    logic             wr_sel_q, wr_sel_d;
    logic [AW-1:0]    wr_idx_q, wr_idx_d;
    logic             rd_sel_q, rd_sel_d;
    logic [AW-1:0]    rd_idx_q, rd_idx_d;

    logic [WIDTH-1:0] bank0_mem [DEPTH];
    logic [WIDTH-1:0] bank1_mem [DEPTH];

    logic             in_ready_c;
    logic             out_valid_c;
    logic             out_last_c;
    logic [LW-1:0]    rd_len_c;
    logic [WIDTH-1:0] rd_word_c;
    logic             wr_fire_c;
    logic             wr_close_c;
    logic             rd_fire_c;
    logic [LW-1:0]    wr_len_c;

    // Status decode: the writer owns wr_sel while it is empty, the reader owns rd_sel while closed.
    always_comb begin
        in_ready_c  = (full_q[wr_sel_q] == BANK_EMPTY);
        out_valid_c = (full_q[rd_sel_q] == BANK_CLOSED);
        rd_len_c    = rd_sel_q ? len1_q : len0_q;
        rd_word_c   = rd_sel_q ? bank1_mem[rd_idx_q] : bank0_mem[rd_idx_q];
        out_last_c  = out_valid_c && (LW'(rd_idx_q) == (rd_len_c - LW'(1)));
        wr_fire_c   = bus_io.in_valid && in_ready_c;
        wr_close_c  = wr_fire_c && (bus_io.in_last || (wr_idx_q == AW'(DEPTH - 1)));
        rd_fire_c   = out_valid_c && bus_io.out_ready;
        wr_len_c    = LW'(wr_idx_q) + LW'(1);
    end

    assign bus_io.in_ready  = in_ready_c;
    assign bus_io.out_valid = out_valid_c;
    assign bus_io.out_data  = out_valid_c ? rd_word_c : '0;
    assign bus_io.out_len   = out_valid_c ? rd_len_c : '0;
    assign bus_io.out_last  = out_last_c;
    assign bus_io.bank_full = full_q;

    // Next state; writer and reader touch disjoint banks, so both updates may land together.
    always_comb begin
        full_d   = full_q;
        len0_d   = len0_q;
        len1_d   = len1_q;
        wr_sel_d = wr_sel_q;
        wr_idx_d = wr_idx_q;
        rd_sel_d = rd_sel_q;
        rd_idx_d = rd_idx_q;

        if (wr_fire_c) begin
            if (wr_close_c) begin
                full_d[wr_sel_q] = BANK_CLOSED;
                if (wr_sel_q) begin
                    len1_d = wr_len_c;
                end else begin
                    len0_d = wr_len_c;
                end
                wr_sel_d = ~wr_sel_q;
                wr_idx_d = '0;
            end else begin
                wr_idx_d = wr_idx_q + AW'(1);
            end
        end

        if (rd_fire_c) begin
            if (out_last_c) begin
                full_d[rd_sel_q] = BANK_EMPTY;
                rd_sel_d = ~rd_sel_q;
                rd_idx_d = '0;
            end else begin
                rd_idx_d = rd_idx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q   <= '0;
            len0_q   <= '0;
            len1_q   <= '0;
            wr_sel_q <= 1'b0;
            wr_idx_q <= '0;
            rd_sel_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            full_q   <= full_d;
            len0_q   <= len0_d;
            len1_q   <= len1_d;
            wr_sel_q <= wr_sel_d;
            wr_idx_q <= wr_idx_d;
            rd_sel_q <= rd_sel_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Storage is deliberately unreset; a bank is only read after it has been written and closed.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            if (wr_sel_q) begin
                bank1_mem[wr_idx_q] <= bus_io.in_data;
            end else begin
                bank0_mem[wr_idx_q] <= bus_io.in_data;
            end
        end
    end

endmodule

// File: tb/tb_pingpong_bank_buffer.sv
// Directed vector table plus scoreboarded streaming/random traffic for pingpong_bank_buffer.
module tb_pingpong_bank_buffer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    pingpong_bank_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pingpong_bank_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       il;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ol;
        logic [2:0] e_len;
        logic [1:0] e_bf;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(logic iv, logic [7:0] id, logic il, logic ordy,
                                logic ir, logic ov, logic [7:0] od, logic ol,
                                logic [2:0] ln, logic [1:0] bf);
        return '{iv, id, il, ordy, ir, ov, od, ol, ln, bf};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, want %0h", nm, got, exp);
        end
    endtask

    task automatic drv(input logic iv, input logic [7:0] d, input logic il, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_last   = il;
        bus.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_outs(input string p, input logic ir, input logic ov, input logic [7:0] od,
                            input logic ol, input logic [2:0] ln, input logic [1:0] bf);
        chk({p, ".in_ready"},  32'(bus.in_ready),  32'(ir));
        chk({p, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({p, ".out_data"},  32'(bus.out_data),  32'(od));
        chk({p, ".out_last"},  32'(bus.out_last),  32'(ol));
        chk({p, ".out_len"},   32'(bus.out_len),   32'(ln));
        chk({p, ".bank_full"}, 32'(bus.bank_full), 32'(bf));
    endtask

    // Scoreboarded traffic; the producer holds each word until it is accepted.
    task automatic run_flow(input string p, input int nwords, input bit rnd,
                            input logic [7:0] base, input int budget);
        logic [7:0] dq[$];
        bit         lq[$];
        int         lenq[$];
        int         sent;
        int         popped;
        int         cyc;
        int         wcnt;
        bit         pend;
        bit         pl;
        bit         closes;
        logic [7:0] pd;
        sent = 0; popped = 0; cyc = 0; wcnt = 0; pend = 1'b0; pl = 1'b0; pd = '0;
        while ((sent < nwords || pend || dq.size() != 0) && cyc < budget) begin
            if (!pend && sent < nwords && (!rnd || $urandom_range(0, 9) < 7)) begin
                pend = 1'b1;
                pd   = 8'(base + 8'(sent));
                sent++;
                pl   = (sent == nwords) || (rnd && $urandom_range(0, 3) == 0);
            end
            bus.in_valid  = pend;
            bus.in_data   = pend ? pd : 8'h00;
            bus.in_last   = pend ? pl : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            bus.out_ready = (!rnd || (sent == nwords && !pend)) ? 1'b1 : ($urandom_range(0, 9) < 6);
            if (pend && bus.in_ready) begin
                closes = pl || (wcnt == int'(DEPTH) - 1);
                dq.push_back(pd);
                lq.push_back(closes);
                if (closes) begin
                    lenq.push_back(wcnt + 1);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
                pend = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (dq.size() == 0 || lenq.size() == 0) begin
                    chk({p, ".unexpected_word"}, 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    chk({p, ".out_data"}, 32'(bus.out_data), 32'(dq[0]));
                    chk({p, ".out_last"}, 32'(bus.out_last), 32'(lq[0]));
                    chk({p, ".out_len"},  32'(bus.out_len),  32'(lenq[0]));
                    if (lq[0]) void'(lenq.pop_front());
                    void'(dq.pop_front());
                    void'(lq.pop_front());
                    popped++;
                end
            end
            tick();
            cyc++;
        end
        chk({p, ".within_budget"}, 32'(cyc < budget), 32'd1);
        chk({p, ".word_count"},    32'(popped),       32'(nwords));
        drv(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        drv(1'b0, 8'h00, 1'b0, 1'b0);

        //                iv   id     il   ordy | ir   ov   od     ol   len   bf
        vecs[0]  = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        vecs[1]  = mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        vecs[2]  = mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        vecs[3]  = mk(1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        vecs[4]  = mk(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 3'd4, 2'b01);
        vecs[5]  = mk(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 3'd4, 2'b01);
        vecs[6]  = mk(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 3'd4, 2'b01);
        vecs[7]  = mk(1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 3'd4, 2'b01);
        vecs[8]  = mk(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3'd4, 2'b11);
        vecs[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 3'd4, 2'b11);
        vecs[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 3'd4, 2'b11);
        vecs[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 3'd4, 2'b11);
        vecs[12] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 3'd4, 2'b11);
        vecs[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 3'd4, 2'b10);
        vecs[14] = mk(1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 3'd4, 2'b10);
        vecs[15] = mk(1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 3'd4, 2'b10);
        vecs[16] = mk(1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 3'd4, 2'b11);
        vecs[17] = mk(1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h88, 1'b1, 3'd4, 2'b11);
        vecs[18] = mk(1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 3'd2, 2'b01);
        vecs[19] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 3'd2, 2'b11);
        vecs[20] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 3'd2, 2'b11);
        vecs[21] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB0, 1'b1, 3'd1, 2'b10);
        vecs[22] = mk(1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        vecs[23] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);

        @(negedge clk);
        chk_outs("reset", 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        reset_n = 1'b1;
        tick();

        // Fill both banks, drain, short and single-word bursts.
        for (int i = 0; i < 24; i++) begin
            chk_outs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od,
                     vecs[i].e_ol, vecs[i].e_len, vecs[i].e_bf);
            drv(vecs[i].iv, vecs[i].id, vecs[i].il, vecs[i].ordy);
            tick();
        end

        // Writer closes bank 1 on the same edge the reader releases bank 0.
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 8'(8'hD0 + 8'(k)), 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("swap%0d.out_data", k), 32'(bus.out_data), 32'(8'hD0 + 8'(k)));
            chk($sformatf("swap%0d.out_last", k), 32'(bus.out_last), 32'(k == 3));
            chk($sformatf("swap%0d.bank_full", k), 32'(bus.bank_full), 32'(2'b01));
            drv(1'b1, 8'(8'hE0 + 8'(k)), 1'b0, 1'b1);
            tick();
        end
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk_outs("swap_after", 1'b1, 1'b1, 8'hE0, 1'b0, 3'd4, 2'b10);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("swap_drain%0d.out_data", k), 32'(bus.out_data), 32'(8'hE0 + 8'(k)));
            drv(1'b0, 8'h00, 1'b0, 1'b1);
            tick();
        end
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk_outs("swap_empty", 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);

        run_flow("stream", 40, 1'b0, 8'h00, 400);
        void'($urandom(32'd20240601));
        run_flow("random", 200, 1'b1, 8'h40, 4000);

        // Reset mid-operation: bank 1 closed and half read, bank 0 half written.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drv(1'b1, 8'(8'hF0 + 8'(k)), 1'b0, 1'b0);
            tick();
        end
        chk("mid.full_both", 32'(bus.bank_full), 32'(2'b11));
        for (int k = 0; k < 4; k++) begin
            drv(1'b0, 8'h00, 1'b0, 1'b1);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drv(1'b1, 8'(8'h90 + 8'(k)), 1'b0, 1'b1);
            tick();
        end
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk_outs("mid_before", 1'b1, 1'b1, 8'hF6, 1'b0, 3'd4, 2'b10);
        reset_n = 1'b0;
        #1;
        chk_outs("mid_reset", 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 8'(8'hC1 + 8'(k)), 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fresh%0d.out_data", k), 32'(bus.out_data), 32'(8'hC1 + 8'(k)));
            chk($sformatf("fresh%0d.out_last", k), 32'(bus.out_last), 32'(k == 3));
            chk($sformatf("fresh%0d.out_len", k),  32'(bus.out_len),  32'd4);
            drv(1'b0, 8'h00, 1'b0, 1'b1);
            tick();
        end
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk_outs("fresh_empty", 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pingpong_bank_buffer.md
Name: pingpong_bank_buffer

Overview:
Parametrised double-bank (ping-pong) buffer between a producer stream and a consumer stream.
- The producer fills one bank of DEPTH words, which is then handed to the consumer as a burst.
- While the consumer drains that bank, the producer fills the other bank.
- Both sides use valid/ready handshakes, so backpressure works in both directions.
- Short bursts are supported via in_last.
- Sits between a bursty source and a block-oriented sink.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, words per bank (>=2). Derived localparam AW = $clog2(DEPTH); length fields are AW+1 bits.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  producer word.
- in_last  input  1  final word of the current burst; closes the bank early; sampled only when in_valid.
- in_ready  output  1  buffer can accept a word this cycle.
- out_valid  output  1  out_data holds a valid word of a closed bank.
- out_data  output  WIDTH  consumer word.
- out_last  output  1  out_data is the final word of the presented bank.
- out_len  output  AW+1  word count of the bank being presented (1..DEPTH).
- out_ready  input  1  consumer accepts out_data this cycle.
- bank_full  output  2  per-bank closed/readable flags, for status.

Behaviour:
- Storage: two banks, each DEPTH x WIDTH. Memory contents are not reset.
- Registered state:
  - full[1:0], len0/len1 (AW+1 bits each)
  - wr_sel, wr_idx (AW bits)
  - rd_sel, rd_idx (AW bits)
- Reset (async, reset_n low), regardless of operation in progress:
  - full=0, wr_sel=0, rd_sel=0, wr_idx=0, rd_idx=0, len0=len1=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, out_len=0, bank_full=0.
  - A partially written bank is discarded.
- Per-bank state: EMPTY (full=0; writable when wr_sel points at it) and CLOSED (full=1; readable when rd_sel points at it). Transitions:
  - EMPTY->CLOSED on a write handshake with wr_idx==DEPTH-1 or in_last=1.
  - CLOSED->EMPTY on a read handshake with out_last=1.
- Write side:
  - in_ready = !full[wr_sel], decoded from registers only. There is no combinational path from out_ready to in_ready.
  - On handshake (in_valid && in_ready): mem[wr_sel][wr_idx] <= in_data.
  - If closing: full[wr_sel]<=1, len[wr_sel]<=wr_idx+1, wr_sel toggles, wr_idx<=0. Otherwise wr_idx increments.
- Read side (first-word-fall-through):
  - out_valid = full[rd_sel].
  - out_data = mem[rd_sel][rd_idx] when out_valid, else 0.
  - out_len = len[rd_sel] when out_valid, else 0.
  - out_last = out_valid && (rd_idx == len[rd_sel]-1).
  - On handshake (out_valid && out_ready): if out_last, full[rd_sel]<=0, rd_sel toggles, rd_idx<=0; otherwise rd_idx increments.
- Latency:
  - A word that closes a bank in cycle N: if that bank is the one rd_sel points to, its first word appears with out_valid=1 in cycle N+1.
  - A bank released by the reader in cycle N: in_ready for that bank rises in cycle N+1.
- Simultaneous events:
  - The writer closing one bank and the reader releasing the other in the same cycle both take effect.
  - The writer never targets a CLOSED bank and the reader never reads an EMPTY one, so the banks are disjoint by construction.
- Both banks CLOSED: in_ready=0; in_data and in_last are ignored until the reader releases a bank.
- Both banks EMPTY: out_valid=0; out_ready is ignored.
- Length-1 burst: in_last on the first word gives out_len=1, and out_last=1 on the sole word.
- in_last on wr_idx==DEPTH-1 is identical to a full close; there is no extra effect.
- wr_idx and rd_idx never exceed DEPTH-1; no wrap beyond bank bounds.
- in_last without in_valid has no effect.
- bank_full mirrors full[1:0] directly.

Test Plan:
1. Reset, then 4 words 0x11,0x22,0x33,0x44 with out_ready=0 (DEPTH=4) -> full=01. out_valid=1 on the cycle after the 4th handshake, out_data=0x11, out_len=4, in_ready=1 (bank 1 free).
2. Continue writing 0x55..0x88 with out_ready=0 -> full=11, in_ready=0. Then out_ready=1 -> reads 0x11,0x22,0x33,0x44, out_last on 0x44. in_ready=1 one cycle after that handshake, and 0x55 is presented next.
3. Short burst 0xA1,0xA2 with in_last on 0xA2 -> out_len=2, out_last=1 on 0xA2. Single word 0xB0 with in_last -> out_len=1, out_last=1 on 0xB0.
4. Continuous in_valid=1 and out_ready=1 with incrementing data for 40 words -> output sequence identical to input, no drops or duplicates, out_last every 4th word.
5. Random in_valid/out_ready toggling (seeded), mixed in_last -> scoreboard order matches and no in_valid&&!in_ready word is lost. On the write cycle closing bank X while the reader releases bank Y: X CLOSED and Y EMPTY on the next cycle.
6. Assert reset_n low mid-burst (2 of 4 words written, bank 1 CLOSED and half read) -> same cycle: out_valid=0, in_ready=1, bank_full=00. After release, a fresh burst 0xC1..0xC4 is read back as exactly 0xC1..0xC4.
